video_dram_arb: RTL and testbench
=================================

Name: video_dram_arb

Overview:
- Cycle-slot arbiter for the shared 16-bit video DRAM port.
- Requesters, in priority order: video fetcher (bandwidth-budgeted bursts), Z80 CPU, tile-map reader (tm) and tile/sprite renderer (ts).
- Decides slot ownership once per 4-clk DRAM cycle (phases c0..c3), muxes the address to the DRAM controller, and generates the per-requester pre_next / next / strobe handshakes consumed by video_top and the CPU bus unit.

Parameters:
- AW, 21, DRAM word address width
- BWW, 5, width of the video bandwidth budget
- CPU_LP_SLOTS, 4, in low-priority mode the CPU is guaranteed one slot per this many consecutive non-video slots

Ports:
- clk  in  1  system clock
- res  in  1  synchronous active-high reset
- c0  in  1  DRAM cycle phase 0 strobe (one-hot with c1..c3)
- c2  in  1  DRAM cycle phase 2 strobe; read data valid
- c3  in  1  DRAM cycle phase 3 strobe; arbitration edge
- video_go  in  1  start of video fetch window; sampled on c3
- video_bw  in  BWW  video slots owed in the window; sampled with video_go
- video_addr  in  AW  video word address
- cpu_req  in  1  CPU access request, held until cpu_next
- cpu_rnw  in  1  1=read, 0=write
- cpu_addr  in  AW  CPU word address
- cpu_wdata  in  16  CPU write data
- cpu_bsel  in  2  write byte enables
- ts_z80_lp  in  1  CPU low-priority mode
- tm_req  in  1  tile-map request
- tm_addr  in  AW  tile-map address
- ts_req  in  1  renderer request
- ts_addr  in  AW  renderer address
- dram_addr  out  AW  muxed address for the owned cycle
- dram_req  out  1  cycle is not idle
- dram_rnw  out  1  read/write for the owned cycle
- dram_wdata  out  16  write data
- dram_bsel  out  2  byte enables
- video_pre_next  out  1  video wins the next slot
- video_next  out  1  video slot completes
- video_strobe  out  1  video data valid
- video_next_strobe  out  1  video_strobe AND another video slot immediately follows
- tm_next  out  1  tm slot completes
- ts_pre_next  out  1  ts wins the next slot
- ts_next  out  1  ts slot completes
- cpu_next  out  1  CPU slot completes
- cpu_strobe  out  1  CPU read data valid
- vid_ovf  out  1  sticky: video_go arrived with budget remaining

Behaviour:
- Owner register
  - owner ∈ {IDLE, VID, CPU, TM, TS}.
  - Loaded only on a clk edge where c3=1.
  - Held through c0..c3 of the following DRAM cycle.
- Video budget
  - vcnt (BWW bits) tracks remaining video slots.
  - On c3 with video_go=1: vcnt <= video_bw. This overrides any decrement.
  - If vcnt!=0 and the current owner is not the final VID slot when video_go arrives, vid_ovf <= 1. vid_ovf clears only on res.
  - Else on c3 with next owner VID: vcnt <= vcnt-1.
  - vcnt saturates at 0 and never wraps.
- Priority, evaluated combinationally during c3:
  1. VID if the effective budget is nonzero (vcnt!=0, or video_go with video_bw!=0).
  2. CPU if cpu_req and !ts_z80_lp.
  3. CPU if cpu_req and ts_z80_lp and lpcnt==CPU_LP_SLOTS-1.
  4. TM if tm_req.
  5. TS if ts_req.
  6. CPU if cpu_req.
  7. IDLE.
- lpcnt (starvation counter)
  - Increments on every non-VID decision where cpu_req=1 and CPU loses.
  - Resets to 0 when CPU wins or cpu_req=0.
- Each requester gets at most one slot per decision. Back-to-back slots to the same requester are allowed.
- pre_next
  - video_pre_next and ts_pre_next are combinational, high only during the c3 clk of the winning decision.
- Owned-cycle outputs
  - dram_addr, dram_rnw, dram_wdata and dram_bsel are registered at the decision edge and stable for the whole owned cycle.
  - dram_rnw=1 for VID, TM and TS.
  - dram_req=0 and dram_addr=0 for IDLE.
- Strobes and next pulses
  - video_strobe / cpu_strobe (reads only) pulse during c2 of the owned cycle.
  - *_next pulses during c3 of the owned cycle; each is one clk wide.
  - cpu_next also fires for writes.
  - video_next_strobe = video_strobe AND the next owner will be VID, using the lookahead decision.
- Simultaneous events: a requester deasserting req mid-cycle does not cancel an already-registered slot; its next still fires.
- Reset (synchronous, any phase)
  - owner=IDLE, vcnt=0, lpcnt=0, vid_ovf=0.
  - All outputs 0.
  - An in-flight slot is abandoned with no next pulse.
  - The first decision occurs at the first c3 after res falls.

Test Plan:
- res high, then video_go with video_bw=3 on c3, tm_req and ts_req high -> exactly 3 consecutive VID slots, then TM owns every following slot until tm_req drops, then TS; video_strobe at c2 in each VID slot; video_next_strobe high in VID slots 1 and 2 only.
- cpu_req with ts_z80_lp=0 against tm_req and ts_req -> CPU wins the next slot; cpu_next one clk at that slot's c3; dram_rnw follows cpu_rnw; write slot has no cpu_strobe and dram_wdata/dram_bsel equal to the inputs.
- ts_z80_lp=1, cpu_req, tm_req and ts_req held high -> CPU served exactly once per 4 slots (TM,TM,TM,CPU repeating).
- video_go with video_bw=5, then a second video_go after 2 slots with video_bw=2 -> vcnt reloads, 2 further VID slots, vid_ovf=1 and stays set until res.
- res asserted at c1 of a TS slot -> no ts_next; all outputs 0 on the next clk; after res drops, the first dram_req follows the first c3.
- video_go with video_bw=0 and no other requests -> owner IDLE, dram_req=0, vid_ovf unchanged.

Source files
------------

// File: rtl/video_dram_arb.sv
// Cycle-slot arbiter for the shared 16-bit video DRAM port: picks one owner per 4-clk DRAM
// cycle at the c3 edge, muxes the access onto the DRAM controller and emits handshakes.
module video_dram_arb #(
  parameter int unsigned AW           = 21,
  parameter int unsigned BWW          = 5,
  parameter int unsigned CPU_LP_SLOTS = 4
) (
  input  logic          clk,
  input  logic          res,
  input  logic          c0,
  input  logic          c2,
  input  logic          c3,
  input  logic          video_go,
  input  logic [BWW-1:0] video_bw,
  input  logic [AW-1:0] video_addr,
  input  logic          cpu_req,
  input  logic          cpu_rnw,
  input  logic [AW-1:0] cpu_addr,
  input  logic [15:0]   cpu_wdata,
  input  logic [1:0]    cpu_bsel,
  input  logic          ts_z80_lp,
  input  logic          tm_req,
  input  logic [AW-1:0] tm_addr,
  input  logic          ts_req,
  input  logic [AW-1:0] ts_addr,
  output logic [AW-1:0] dram_addr,
  output logic          dram_req,
  output logic          dram_rnw,
  output logic [15:0]   dram_wdata,
  output logic [1:0]    dram_bsel,
  output logic          video_pre_next,
  output logic          video_next,
  output logic          video_strobe,
  output logic          video_next_strobe,
  output logic          tm_next,
  output logic          ts_pre_next,
  output logic          ts_next,
  output logic          cpu_next,
  output logic          cpu_strobe,
  output logic          vid_ovf
);

  localparam int unsigned LPW = (CPU_LP_SLOTS > 2) ? $clog2(CPU_LP_SLOTS) : 1;
  localparam logic [LPW-1:0] LpMax = LPW'(CPU_LP_SLOTS - 1);

  typedef enum logic [2:0] {OwnIdle, OwnVid, OwnCpu, OwnTm, OwnTs} owner_e;

  owner_e          owner_q, win;
  logic [BWW-1:0]  vcnt_q, vbudget;
  logic [LPW-1:0]  lpcnt_q;
  logic            vid_ovf_q;
  logic [AW-1:0]   dram_addr_q;
  logic            dram_req_q, dram_rnw_q;
  logic [15:0]     dram_wdata_q;
  logic [1:0]      dram_bsel_q;
  logic            unused_c0;

  assign unused_c0 = c0;

  // A fresh video_go replaces the remaining budget; the slot granted with it counts against it.
  always_comb begin
    vbudget = video_go ? video_bw : vcnt_q;
    win     = OwnIdle;
    if (vbudget != '0)                                        win = OwnVid;
    else if (cpu_req && (!ts_z80_lp || lpcnt_q == LpMax))     win = OwnCpu;
    else if (tm_req)                                          win = OwnTm;
    else if (ts_req)                                          win = OwnTs;
    else if (cpu_req)                                         win = OwnCpu;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      owner_q      <= OwnIdle;
      vcnt_q       <= '0;
      lpcnt_q      <= '0;
      vid_ovf_q    <= 1'b0;
      dram_addr_q  <= '0;
      dram_req_q   <= 1'b0;
      dram_rnw_q   <= 1'b0;
      dram_wdata_q <= '0;
      dram_bsel_q  <= '0;
    end else if (c3) begin
      owner_q <= win;
      vcnt_q  <= (win == OwnVid) ? vbudget - BWW'(1) : vbudget;
      if (video_go && vcnt_q != '0) vid_ovf_q <= 1'b1;
      if (!cpu_req || win == OwnCpu)                lpcnt_q <= '0;
      else if (win != OwnVid && lpcnt_q != LpMax)   lpcnt_q <= lpcnt_q + LPW'(1);
      dram_req_q   <= (win != OwnIdle);
      dram_wdata_q <= (win == OwnCpu) ? cpu_wdata : '0;
      dram_bsel_q  <= (win == OwnCpu) ? cpu_bsel : '0;
      case (win)
        OwnVid:  begin dram_addr_q <= video_addr; dram_rnw_q <= 1'b1;    end
        OwnCpu:  begin dram_addr_q <= cpu_addr;   dram_rnw_q <= cpu_rnw; end
        OwnTm:   begin dram_addr_q <= tm_addr;    dram_rnw_q <= 1'b1;    end
        OwnTs:   begin dram_addr_q <= ts_addr;    dram_rnw_q <= 1'b1;    end
        default: begin dram_addr_q <= '0;         dram_rnw_q <= 1'b0;    end
      endcase
    end
  end

  assign dram_addr  = dram_addr_q;
  assign dram_req   = dram_req_q;
  assign dram_rnw   = dram_rnw_q;
  assign dram_wdata = dram_wdata_q;
  assign dram_bsel  = dram_bsel_q;
  assign vid_ovf    = vid_ovf_q;

  // Pulses are masked during reset so an abandoned slot never reports completion.
  assign video_pre_next    = !res && c3 && (win == OwnVid);
  assign ts_pre_next       = !res && c3 && (win == OwnTs);
  assign video_strobe      = !res && c2 && (owner_q == OwnVid);
  assign video_next_strobe = video_strobe && (win == OwnVid);
  assign cpu_strobe        = !res && c2 && (owner_q == OwnCpu) && dram_rnw_q;
  assign video_next        = !res && c3 && (owner_q == OwnVid);
  assign cpu_next          = !res && c3 && (owner_q == OwnCpu);
  assign tm_next           = !res && c3 && (owner_q == OwnTm);
  assign ts_next           = !res && c3 && (owner_q == OwnTs);

endmodule

// File: tb/tb_video_dram_arb.sv
// Bench for video_dram_arb: directed slot table, a reset-abandon sequence and randomized traffic,
// all compared every clock against a slot-level reference model.
module tb_video_dram_arb;

  localparam int LP = 4;
  localparam int O_IDLE = 0, O_VID = 1, O_CPU = 2, O_TM = 3, O_TS = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        res, c0, c2, c3, video_go, cpu_req, cpu_rnw, ts_z80_lp, tm_req, ts_req;
  logic [4:0]  video_bw;
  logic [20:0] video_addr, cpu_addr, tm_addr, ts_addr, dram_addr;
  logic [15:0] cpu_wdata, dram_wdata;
  logic [1:0]  cpu_bsel, dram_bsel;
  logic dram_req, dram_rnw, video_pre_next, video_next, video_strobe, video_next_strobe;
  logic tm_next, ts_pre_next, ts_next, cpu_next, cpu_strobe, vid_ovf;

  video_dram_arb dut (
    .clk(clk), .res(res), .c0(c0), .c2(c2), .c3(c3),
    .video_go(video_go), .video_bw(video_bw), .video_addr(video_addr),
    .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_bsel(cpu_bsel), .ts_z80_lp(ts_z80_lp), .tm_req(tm_req), .tm_addr(tm_addr),
    .ts_req(ts_req), .ts_addr(ts_addr), .dram_addr(dram_addr), .dram_req(dram_req),
    .dram_rnw(dram_rnw), .dram_wdata(dram_wdata), .dram_bsel(dram_bsel),
    .video_pre_next(video_pre_next), .video_next(video_next), .video_strobe(video_strobe),
    .video_next_strobe(video_next_strobe), .tm_next(tm_next), .ts_pre_next(ts_pre_next),
    .ts_next(ts_next), .cpu_next(cpu_next), .cpu_strobe(cpu_strobe), .vid_ovf(vid_ovf)
  );

  int checks = 0, errors = 0;
  int ph = 0;
  int n_vs = 0, n_vns = 0, n_tsn = 0;

  // Reference model state: who owns the current DRAM cycle and what was latched for it.
  int          m_owner, m_vcnt, m_lp;
  bit          m_ovf, m_req, m_rnw;
  logic [20:0] m_addr;
  logic [15:0] m_wdata;
  logic [1:0]  m_bsel;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
    end
  endtask

  function automatic int budget();
    return video_go ? int'(video_bw) : m_vcnt;
  endfunction

  function automatic int m_win();
    if (budget() != 0) return O_VID;
    if (cpu_req && (!ts_z80_lp || m_lp == LP - 1)) return O_CPU;
    if (tm_req) return O_TM;
    if (ts_req) return O_TS;
    if (cpu_req) return O_CPU;
    return O_IDLE;
  endfunction

  task automatic model_reset();
    m_owner = O_IDLE; m_vcnt = 0; m_lp = 0; m_ovf = 0;
    m_req = 0; m_rnw = 0; m_addr = '0; m_wdata = '0; m_bsel = '0;
  endtask

  task automatic model_edge();
    int w, b;
    if (res) begin
      model_reset();
    end else if (ph == 3) begin
      w = m_win();
      b = budget();
      if (video_go && m_vcnt != 0) m_ovf = 1;
      m_vcnt = (w == O_VID) ? b - 1 : b;
      if (!cpu_req || w == O_CPU) m_lp = 0;
      else if (w != O_VID && m_lp < LP - 1) m_lp++;
      m_owner = w;
      m_req   = (w != O_IDLE);
      m_rnw   = (w == O_CPU) ? cpu_rnw : (w != O_IDLE);
      m_wdata = (w == O_CPU) ? cpu_wdata : 16'h0;
      m_bsel  = (w == O_CPU) ? cpu_bsel : 2'b00;
      case (w)
        O_VID:   m_addr = video_addr;
        O_CPU:   m_addr = cpu_addr;
        O_TM:    m_addr = tm_addr;
        O_TS:    m_addr = ts_addr;
        default: m_addr = '0;
      endcase
    end
  endtask

  task automatic check_clk();
    int w;
    bit nr, vs;
    w  = m_win();
    nr = !res;
    vs = nr && ph == 2 && m_owner == O_VID;
    chk("dram_addr", 32'(dram_addr), 32'(m_addr));
    chk("dram_req", 32'(dram_req), 32'(m_req));
    chk("dram_rnw", 32'(dram_rnw), 32'(m_rnw));
    chk("dram_wdata", 32'(dram_wdata), 32'(m_wdata));
    chk("dram_bsel", 32'(dram_bsel), 32'(m_bsel));
    chk("vid_ovf", 32'(vid_ovf), 32'(m_ovf));
    chk("video_pre_next", 32'(video_pre_next), 32'(nr && ph == 3 && w == O_VID));
    chk("ts_pre_next", 32'(ts_pre_next), 32'(nr && ph == 3 && w == O_TS));
    chk("video_strobe", 32'(video_strobe), 32'(vs));
    chk("video_next_strobe", 32'(video_next_strobe), 32'(vs && w == O_VID));
    chk("cpu_strobe", 32'(cpu_strobe), 32'(nr && ph == 2 && m_owner == O_CPU && m_rnw));
    chk("video_next", 32'(video_next), 32'(nr && ph == 3 && m_owner == O_VID));
    chk("cpu_next", 32'(cpu_next), 32'(nr && ph == 3 && m_owner == O_CPU));
    chk("tm_next", 32'(tm_next), 32'(nr && ph == 3 && m_owner == O_TM));
    chk("ts_next", 32'(ts_next), 32'(nr && ph == 3 && m_owner == O_TS));
    if (video_strobe === 1'b1) n_vs++;
    if (video_next_strobe === 1'b1) n_vns++;
    if (ts_next === 1'b1) n_tsn++;
  endtask

  // One clock: present the phase, compare mid-cycle, then let the edge update DUT and model.
  task automatic step();
    c0 = (ph == 0); c2 = (ph == 2); c3 = (ph == 3);
    #2;
    check_clk();
    @(posedge clk);
    model_edge();
    #1;
    ph = (ph + 1) % 4;
  endtask

  typedef struct {
    bit go; logic [4:0] bw; bit cpu; bit rnw; bit lp; bit tm; bit ts;
    logic [20:0] addr; bit req; bit rnwx; bit ovf;
  } vec_t;

  localparam logic [20:0] VA = 21'h00100, CA = 21'h00200, TMA = 21'h00300, TSA = 21'h00400;

  function automatic vec_t mk(bit go, int bw, bit cpu, bit rnw, bit lp, bit tm, bit ts,
                              int own, bit ovf);
    vec_t v;
    v.go = go; v.bw = 5'(bw); v.cpu = cpu; v.rnw = rnw; v.lp = lp; v.tm = tm; v.ts = ts;
    v.ovf = ovf;
    v.req = (own != O_IDLE);
    v.rnwx = (own == O_CPU) ? rnw : (own != O_IDLE);
    case (own)
      O_VID:   v.addr = VA;
      O_CPU:   v.addr = CA;
      O_TM:    v.addr = TMA;
      O_TS:    v.addr = TSA;
      default: v.addr = '0;
    endcase
    return v;
  endfunction

  vec_t vt[22];

  initial begin
    vt[0]  = mk(1, 3, 0, 1, 0, 1, 1, O_VID, 0);
    vt[1]  = mk(0, 0, 0, 1, 0, 1, 1, O_VID, 0);
    vt[2]  = mk(0, 0, 0, 1, 0, 1, 1, O_VID, 0);
    vt[3]  = mk(0, 0, 0, 1, 0, 1, 1, O_TM, 0);
    vt[4]  = mk(0, 0, 0, 1, 0, 1, 1, O_TM, 0);
    vt[5]  = mk(0, 0, 0, 1, 0, 0, 1, O_TS, 0);
    vt[6]  = mk(0, 0, 1, 1, 0, 1, 1, O_CPU, 0);
    vt[7]  = mk(0, 0, 1, 0, 0, 1, 1, O_CPU, 0);
    vt[8]  = mk(0, 0, 1, 1, 1, 1, 1, O_TM, 0);
    vt[9]  = mk(0, 0, 1, 1, 1, 1, 1, O_TM, 0);
    vt[10] = mk(0, 0, 1, 1, 1, 1, 1, O_TM, 0);
    vt[11] = mk(0, 0, 1, 1, 1, 1, 1, O_CPU, 0);
    vt[12] = mk(0, 0, 1, 1, 1, 1, 1, O_TM, 0);
    vt[13] = mk(0, 0, 1, 1, 1, 1, 1, O_TM, 0);
    vt[14] = mk(0, 0, 1, 1, 1, 1, 1, O_TM, 0);
    vt[15] = mk(0, 0, 1, 1, 1, 1, 1, O_CPU, 0);
    vt[16] = mk(1, 0, 0, 1, 0, 0, 0, O_IDLE, 0);
    vt[17] = mk(1, 5, 0, 1, 0, 0, 0, O_VID, 0);
    vt[18] = mk(0, 0, 0, 1, 0, 0, 0, O_VID, 0);
    vt[19] = mk(1, 2, 0, 1, 0, 0, 0, O_VID, 1);
    vt[20] = mk(0, 0, 0, 1, 0, 0, 0, O_VID, 1);
    vt[21] = mk(0, 0, 0, 1, 0, 0, 0, O_IDLE, 1);

    res = 1; video_go = 0; video_bw = 0; cpu_req = 0; cpu_rnw = 1; ts_z80_lp = 0;
    tm_req = 0; ts_req = 0; video_addr = VA; cpu_addr = CA; tm_addr = TMA; ts_addr = TSA;
    cpu_wdata = 16'hA5C3; cpu_bsel = 2'b10;
    c0 = 1; c2 = 0; c3 = 0;
    @(posedge clk);
    model_reset();
    #1;
    repeat (4) step();
    res = 0;

    // Directed slot table: inputs held for one full DRAM cycle, owner checked after its c3.
    for (int i = 0; i < 22; i++) begin
      if (i == 1) begin n_vs = 0; n_vns = 0; end
      if (i == 4) begin
        chk("vid_strobe_count", 32'(n_vs), 32'd3);
        chk("vid_next_strobe_count", 32'(n_vns), 32'd2);
      end
      video_go = vt[i].go; video_bw = vt[i].bw; cpu_req = vt[i].cpu; cpu_rnw = vt[i].rnw;
      ts_z80_lp = vt[i].lp; tm_req = vt[i].tm; ts_req = vt[i].ts;
      repeat (4) step();
      chk($sformatf("tbl%0d_addr", i), 32'(dram_addr), 32'(vt[i].addr));
      chk($sformatf("tbl%0d_req", i), 32'(dram_req), 32'(vt[i].req));
      chk($sformatf("tbl%0d_rnw", i), 32'(dram_rnw), 32'(vt[i].rnwx));
      chk($sformatf("tbl%0d_ovf", i), 32'(vid_ovf), 32'(vt[i].ovf));
      if (i == 7) begin
        chk("wr_wdata", 32'(dram_wdata), 32'h0000A5C3);
        chk("wr_bsel", 32'(dram_bsel), 32'd2);
      end
    end

    // Reset landing in c1 of a TS slot abandons it; the next c3 makes the first new decision.
    video_go = 0; cpu_req = 0; tm_req = 0; ts_req = 1; ts_z80_lp = 0;
    repeat (4) step();
    chk("rst_ts_owned", 32'(dram_addr), 32'(TSA));
    n_tsn = 0;
    step();
    res = 1;
    step();
    res = 0;
    chk("rst_req_cleared", 32'(dram_req), 32'd0);
    chk("rst_addr_cleared", 32'(dram_addr), 32'd0);
    chk("rst_ovf_cleared", 32'(vid_ovf), 32'd0);
    step();
    chk("rst_req_before_c3", 32'(dram_req), 32'd0);
    step();
    chk("rst_no_ts_next", 32'(n_tsn), 32'd0);
    chk("rst_first_req_after_c3", 32'(dram_req), 32'd1);

    // Randomized traffic with occasional resets at arbitrary phases.
    for (int s = 0; s < 300; s++) begin
      video_go  = ($urandom_range(0, 5) == 0);
      video_bw  = 5'($urandom_range(0, 6));
      cpu_req   = $urandom_range(0, 1) == 1;
      cpu_rnw   = $urandom_range(0, 1) == 1;
      ts_z80_lp = $urandom_range(0, 1) == 1;
      tm_req    = $urandom_range(0, 2) != 0;
      ts_req    = $urandom_range(0, 1) == 1;
      video_addr = 21'($urandom); cpu_addr = 21'($urandom);
      tm_addr    = 21'($urandom); ts_addr  = 21'($urandom);
      cpu_wdata  = 16'($urandom); cpu_bsel = 2'($urandom);
      for (int k = 0; k < 4; k++) begin
        res = ($urandom_range(0, 149) == 0);
        step();
      end
      res = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
